// File: rtl/imem_loader.sv
// Program loader: splits a stream of 32-bit instruction words into big-endian
// byte writes on the instruction-memory write port, one word per five cycles.
module imem_loader #(
  parameter int ADDR_W   = 32,
  parameter int MEM_SIZE = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_count
);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, FINISH} state_t;

  // Highest byte address at which a whole word still fits in memory.
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_SIZE - 4);

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       wbuf;
  logic              last_q;
  logic [1:0]        idx;
  logic              overflow;

  assign overflow = ptr > LAST_WORD;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCEPT;
      ACCEPT:  if (in_valid) state_next = overflow ? FINISH : WRITE;
      WRITE:   if (idx == 2'd3) state_next = last_q ? FINISH : ACCEPT;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      wbuf       <= '0;
      last_q     <= 1'b0;
      idx        <= 2'd0;
      word_count <= 16'd0;
      error      <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            ptr        <= base_addr & ~ADDR_W'(3);
            word_count <= 16'd0;
            error      <= 1'b0;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            // The bounds check precedes any byte write, so a word never lands partially.
            if (overflow) begin
              error <= 1'b1;
            end else begin
              wbuf   <= in_data;
              last_q <= in_last;
              idx    <= 2'd0;
            end
          end
        end
        WRITE: begin
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            ptr <= ptr + ADDR_W'(4);
            if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs: decoded from the state and datapath registers only.
  always_comb begin
    in_ready  = (state == ACCEPT);
    mem_we    = (state == WRITE);
    busy      = (state != IDLE);
    done      = (state == FINISH);
    mem_addr  = '0;
    mem_wdata = 8'd0;
    if (state == WRITE) begin
      mem_addr = ptr + ADDR_W'(idx);
      case (idx)
        2'd0:    mem_wdata = wbuf[31:24];
        2'd1:    mem_wdata = wbuf[23:16];
        2'd2:    mem_wdata = wbuf[15:8];
        default: mem_wdata = wbuf[7:0];
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a schedule-queue reference model checked
// every cycle, directed scenarios with literal expectations, then random sessions.
module tb_imem_loader;

  localparam int ADDR_W   = 32;
  localparam int MEM_SIZE = 2048;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              in_valid = 1'b0;
  logic [31:0]       in_data = '0;
  logic              in_last = 1'b0;
  logic              in_ready, mem_we, busy, done, error;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [15:0]       word_count;

  imem_loader #(.ADDR_W(ADDR_W), .MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for one clock cycle.
  typedef struct {
    bit          ready, we, busy, done, err;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic [15:0] wc;
  } exp_t;

  function automatic exp_t rec(bit ready, bit we, bit bsy, bit dn, bit err,
                               logic [31:0] addr, logic [7:0] d, logic [15:0] wc);
    exp_t r;
    r.ready = ready; r.we = we; r.busy = bsy; r.done = dn; r.err = err;
    r.addr = addr; r.wdata = d; r.wc = wc;
    return r;
  endfunction

  // Bytes the DUT actually wrote, for literal spot checks of the memory image.
  logic [7:0] image [0:MEM_SIZE-1];

  // Reference model: a session is open or not; a handshake schedules the next
  // few cycles of output into a queue; an empty queue in a session means waiting.
  exp_t        sched[$];
  exp_t        cur, nxt;
  bit          cur_valid = 0;
  bit          session = 0;
  logic [31:0] m_ptr = '0;
  logic [15:0] m_wc = '0;
  bit          m_err = 0;

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) image[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (cur_valid) begin
        check("in_ready",   in_ready,   cur.ready);
        check("mem_we",     mem_we,     cur.we);
        check("busy",       busy,       cur.busy);
        check("done",       done,       cur.done);
        check("error",      error,      cur.err);
        check("word_count", word_count, cur.wc);
        if (cur.we) begin
          check("mem_addr",  mem_addr,  cur.addr);
          check("mem_wdata", mem_wdata, cur.wdata);
        end
      end
      if (mem_we === 1'b1 && mem_addr < MEM_SIZE) image[mem_addr] = mem_wdata;

      if (rst === 1'b1) begin
        sched.delete();
        session = 0; m_wc = '0; m_err = 0;
        cur = rec(0, 0, 0, 0, 0, '0, '0, '0);
        cur_valid = 1;
      end else if (cur_valid) begin
        if (!cur.busy) begin
          if (start) begin
            session = 1;
            m_ptr = {base_addr[31:2], 2'b00};
            m_wc = '0;
            m_err = 0;
          end
        end else if (cur.ready && in_valid) begin
          if (64'(m_ptr) + 64'd4 > 64'(MEM_SIZE)) begin
            m_err = 1;
            sched.push_back(rec(0, 0, 1, 1, 1, '0, '0, m_wc));
          end else begin
            for (int b = 0; b < 4; b++)
              sched.push_back(rec(0, 1, 1, 0, 0, m_ptr + 32'(b),
                                  8'((in_data >> (8 * (3 - b))) & 32'hFF), m_wc));
            m_ptr = m_ptr + 32'd4;
            if (m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
            if (in_last) sched.push_back(rec(0, 0, 1, 1, m_err, '0, '0, m_wc));
          end
        end else if (cur.done) begin
          session = 0;
        end
        if (sched.size() > 0) nxt = sched.pop_front();
        else if (session)     nxt = rec(1, 0, 1, 0, m_err, '0, '0, m_wc);
        else                  nxt = rec(0, 0, 0, 0, m_err, '0, '0, m_wc);
        cur = nxt;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] wq[$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] d, input bit last);
    bit hs = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    for (int i = 0; i < 40 && !hs; i++) begin
      @(negedge clk);
      hs = in_ready;
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = $urandom;
    check("handshake_seen", 32'(hs), 32'd1);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    tick();
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic session_run(input logic [31:0] base, input int stall, input bit spur);
    logic [31:0] a;
    int n;
    a = {base[31:2], 2'b00};
    n = wq.size();
    start = 1'b1; base_addr = base;
    tick();
    start = 1'b0; base_addr = $urandom;
    for (int k = 0; k < n; k++) begin
      repeat (stall) tick();
      send_word(wq[k], k == n - 1);
      if (64'(a) + 64'd4 > 64'(MEM_SIZE)) break;
      a = a + 32'd4;
      if (spur && k == 0) begin
        start = 1'b1; base_addr = 32'h600;
        tick();
        start = 1'b0;
      end
    end
    wait_done();
    wq.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},   in_ready,   0);
    check({tag, "_mem_we"},     mem_we,     0);
    check({tag, "_mem_addr"},   mem_addr,   0);
    check({tag, "_mem_wdata"},  mem_wdata,  0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_done"},       done,       0);
    check({tag, "_error"},      error,      0);
    check({tag, "_word_count"}, word_count, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_values("reset");
    tick();

    // Single word at address 0.
    wq.push_back(32'hE3A00014);
    session_run(32'h0, 0, 0);
    check("t1_wc",  word_count, 1);
    check("t1_b0",  image[0], 8'hE3);
    check("t1_b1",  image[1], 8'hA0);
    check("t1_b2",  image[2], 8'h00);
    check("t1_b3",  image[3], 8'h14);

    // Three words at an unaligned base; writes start at 0x10.
    wq.push_back(32'h11223344); wq.push_back(32'h55667788); wq.push_back(32'h99AABBCC);
    session_run(32'h13, 0, 0);
    check("t2_wc",   word_count, 3);
    check("t2_0x10", image[16'h10], 8'h11);
    check("t2_0x17", image[16'h17], 8'h88);
    check("t2_0x1B", image[16'h1B], 8'hCC);

    // Overflow: first word fills the last slot, second is rejected.
    wq.push_back(32'hE1A00000); wq.push_back(32'hDEADBEEF);
    session_run(32'h7FC, 0, 0);
    check("t3_wc",    word_count, 1);
    check("t3_err",   error, 1);
    check("t3_0x7FC", image[16'h7FC], 8'hE1);
    check("t3_0x7FD", image[16'h7FD], 8'hA0);
    check("t3_0x7FF", image[16'h7FF], 8'h00);

    // Source stalls for 7 cycles in ACCEPT.
    wq.push_back(32'hCAFEF00D);
    session_run(32'h100, 7, 0);
    check("t4_err",   error, 0);
    check("t4_0x100", image[16'h100], 8'hCA);
    check("t4_0x103", image[16'h103], 8'h0D);

    // Reset on the byte-2 cycle of a word.
    start = 1'b1; base_addr = 32'h40;
    tick();
    start = 1'b0;
    send_word(32'hAABBCCDD, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("midrst");
    tick();
    wq.push_back(32'h01020304);
    session_run(32'h200, 0, 0);
    check("t5_wc",    word_count, 1);
    check("t5_0x200", image[16'h200], 8'h01);
    check("t5_0x203", image[16'h203], 8'h04);

    // in_valid while idle, and a start pulse during WRITE, are both ignored.
    in_valid = 1'b1; in_data = 32'h0BADF00D; in_last = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    wq.push_back(32'h12345678); wq.push_back(32'h9ABCDEF0);
    session_run(32'h300, 0, 1);
    check("t6_wc",    word_count, 2);
    check("t6_0x304", image[16'h304], 8'h9A);
    check("t6_0x600", image[16'h600], 8'h00);

    // Random sessions.
    for (int s = 0; s < 40; s++) begin
      logic [31:0] base;
      int sel;
      sel = $urandom_range(0, 3);
      if (sel < 2)       base = $urandom_range(0, 32'h7F0);
      else if (sel == 2) base = $urandom_range(32'h7E0, 32'h7FF);
      else               base = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b1; in_data = $urandom; in_last = 1'($urandom);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
      end
      for (int k = 0, n = $urandom_range(1, 5); k < n; k++) wq.push_back($urandom);
      session_run(base, $urandom_range(0, 2), $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes a stream of 32-bit ARM instruction words into the byte-wide instruction memory through its write port. Each word is split into four bytes and stored big-endian: the most significant byte goes to the lowest address, so the fetch side reassembles the word as `{data[a], data[a+1], data[a+2], data[a+3]}`. The loader sits between a host/boot stream source and the instruction memory write port. It holds `busy` high so the core can be stalled until the program image is resident.

## Interface
Parameters:
- `ADDR_W`, 32, width of memory byte address.
- `MEM_SIZE`, 2048, instruction memory size in bytes; must be a multiple of 4.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle pulse that begins a load session.
- `base_addr`  in  ADDR_W  first byte address of the session; bits [1:0] are forced to 0 at latch.
- `in_valid`  in  1  source has a word on `in_data`.
- `in_data`  in  32  instruction word.
- `in_last`  in  1  qualifies `in_data` as the final word of the session.
- `in_ready`  out  1  loader accepts a word this cycle.
- `mem_we`  out  1  byte write strobe to instruction memory.
- `mem_addr`  out  ADDR_W  byte address for the write.
- `mem_wdata`  out  8  byte to write.
- `busy`  out  1  session in progress (any state except IDLE).
- `done`  out  1  one-cycle pulse at session end.
- `error`  out  1  sticky overflow flag; cleared by the next accepted `start` or by `rst`.
- `word_count`  out  16  words fully written in the current or last session.

## Operation
States are IDLE, ACCEPT, WRITE and FINISH. All outputs are registered or decoded from the state register only (Moore).
- **IDLE**
  - `in_ready`=0; `in_valid` is ignored.
  - `start`=1 latches `ptr`={base_addr[ADDR_W-1:2],2'b00}, clears `word_count` and `error`, and moves to ACCEPT.
- **ACCEPT**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`:
    - If `ptr` > MEM_SIZE-4: set `error`, write nothing, go to FINISH.
    - Otherwise capture `in_data` into `wbuf` and `in_last` into `last_q`, set `idx`=0, and go to WRITE.
- **WRITE**
  - `in_ready`=0.
  - `mem_we`=1 and `mem_addr`=`ptr`+`idx` every cycle.
  - `mem_wdata` = `wbuf`[31:24], [23:16], [15:8], [7:0] for `idx` = 0, 1, 2, 3 respectively.
  - `idx` increments each cycle. After `idx`=3: `ptr` += 4, `word_count` += 1, then go to FINISH if `last_q`, else ACCEPT.
- **FINISH**: `done`=1 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored.
- Address arithmetic is ADDR_W bits and is never allowed to wrap: the overflow check runs before any byte of the word is written. A word is therefore written entirely or not at all.
- `word_count` saturates at 16'hFFFF.
- Reset mid-session: the next state is IDLE. `mem_we`, `in_ready`, `busy`, `done` and `error` are 0 from the first cycle after the reset edge. `word_count` resets to 0. A partially written word is left partial in memory; this is allowed.

## Timing
- Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `error`=0, `word_count`=0.
- Start latency: `start` sampled at edge t puts the loader in ACCEPT from cycle t+1, so `in_ready` is high in cycle t+1.
- Per-word latency: handshake in cycle h gives `mem_we` high in cycles h+1..h+4 with byte indices 0..3. `in_ready` returns in cycle h+5 (non-last word), or `done` is high in cycle h+5 (last word).
- Throughput is one word per 5 cycles. There is no back-pressure on the memory side: the write port is assumed always ready.
- `word_count` updates at the edge that ends the cycle carrying byte 3.
- Overflow: handshake in cycle h gives `error`=1 and `done`=1 in cycle h+1, with no `mem_we`.
- `busy` is high from cycle t+1 through the FINISH cycle inclusive.

## Test plan
- **Single word:** `start` with `base_addr`=0x0, then one word 0xE3A00014 with `in_last`=1. Expect writes to 0..3 of E3,A0,00,14 in four consecutive cycles, `done` one cycle later, and `word_count`=1.
- **Three-word burst at unaligned base:** `base_addr`=0x13. Writes begin at 0x10; word k lands at 0x10+4k in big-endian byte order. Expect `word_count`=3 and no `mem_we` in any ACCEPT cycle.
- **Overflow:** MEM_SIZE=2048, `base_addr`=0x7FC, two words. The first word is written to 0x7FC..0x7FF. The second is accepted, then `error`=1 and `done`=1 with no further writes; `word_count`=1.
- **Source stalls:** hold `in_valid` low for 7 cycles in ACCEPT. `in_ready` stays 1 and `mem_we` stays 0; the word is written correctly once `in_valid` rises.
- **Reset mid-write:** assert `rst` on the byte 2 cycle. All outputs are at reset values the next cycle, and a fresh `start` session works normally.
- **Ignored inputs:** `start` pulsed during WRITE, and `in_valid` asserted while in IDLE. Neither has any effect and no words are consumed.
